apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Parametrised APB master bridge between the CPU request port and NSLV APB slaves (UART, GPIO, ...).
//  Accepts one transfer per valid/ready handshake and decodes the target slave from the upper address bits.
//  Runs the IDLE/SETUP/ACCESS protocol, handles wait states, and returns read data plus a coded status.
//  Adds a decode-error path and a per-transfer PREADY timeout.
// PARAMETERS
//  AW       5   address width (paddr, req_addr)
//  DW       32  data width (pwdata, prdata, rsp_rdata)
//  NSLV     2   number of APB slaves (1..2**(AW-SEL_LSB))
//  SEL_LSB  3   slave index = req_addr[AW-1:SEL_LSB]
//  TIMEOUT  16  max ACCESS cycles without pready; 0 disables the timeout
// PORTS
//  pclk       in   1        APB clock, all logic on rising edge
//  Reset      in   1        asynchronous, active-high reset
//  req_valid  in   1        CPU transfer request
//  req_ready  out  1        bridge can accept a request (high only in IDLE)
//  req_write  in   1        1=write, 0=read
//  req_addr   in   AW       transfer address
//  req_wdata  in   DW       write data
//  rsp_valid  out  1        one-cycle completion pulse
//  rsp_rdata  out  DW       read data; valid when rsp_valid && read && rsp_code==OK
//  rsp_code   out  2        0 OK, 1 SLVERR, 2 DECODE_ERR, 3 TIMEOUT
//  psel       out  NSLV     one-hot slave select
//  penable    out  1        APB enable
//  pwrite     out  1        APB direction
//  paddr      out  AW       APB address
//  pwdata     out  DW       APB write data
//  pready     in   NSLV     per-slave ready
//  pslverr    in   NSLV     per-slave error
//  prdata     in   NSLV*DW  per-slave read data; slave i at [i*DW +: DW]
// BEHAVIOUR
//  Reset (async): state=IDLE, timeout counter=0. All outputs 0 except req_ready=1.
//   A transfer in flight is dropped; no rsp_valid is issued for it.
//  Accept: req_valid && req_ready sampled at an edge. req_write, req_addr and req_wdata are
//   registered into paddr/pwrite/pwdata and held stable until the transfer ends.
//  Decode: idx = req_addr[AW-1:SEL_LSB].
//   idx >= NSLV: no APB activity; next cycle rsp_valid=1, rsp_code=2, state stays IDLE.
//  FSM IDLE -> SETUP -> ACCESS -> IDLE:
//   SETUP (1 cycle): psel[idx]=1, penable=0.
//   ACCESS: psel[idx]=1, penable=1. Each cycle, sample pready[idx]:
//    pready=1 -> next cycle: IDLE, psel=0, penable=0, rsp_valid=1,
//     rsp_code = pslverr[idx] ? 1 : 0, rsp_rdata = prdata[idx] (reads only; held on writes).
//    pready=0 -> stay in ACCESS; counter++.
//    Counter reaches TIMEOUT-1 with pready=0 -> abort: next cycle IDLE, psel=0, penable=0,
//     rsp_valid=1, rsp_code=3.
//  Latency: zero-wait transfer = accept edge + SETUP + ACCESS; rsp_valid in cycle 3 after the accept edge.
//  Back-to-back: req_ready=1 in the rsp_valid cycle; a new request may be accepted that same cycle.
//  pready/pslverr of unselected slaves are ignored. pready in SETUP is ignored.
//  req_* changes after the accept edge have no effect on the transfer in flight.
//  rsp_rdata holds its last value between responses. rsp_code is meaningful only while rsp_valid=1.
//  Counter width = $clog2(TIMEOUT+1); cleared on every SETUP entry.
// STRUCTURE
//  apb_pkg: state encodings (IDLE/SETUP/ACCESS) and rsp_code constants (RSP_OK, RSP_SLVERR,
//   RSP_DECERR, RSP_TIMEOUT), shared with the slave blocks.
//  Sub-module apb_addr_decoder: combinational req_addr -> one-hot sel[NSLV] plus a dec_err flag.
//  Remainder (FSM, timeout counter, read-data mux, response registers) lives in this module.
// TESTING
//  1 Zero-wait write: addr=0x02, data=0xDEADBEEF, pready[0]=1 -> psel=01 in SETUP and ACCESS,
//    pwdata=0xDEADBEEF, rsp_valid 3 cycles after accept, rsp_code=0.
//  2 Read with 2 wait states: addr=0x0A (slave 1), prdata[1]=0x12345678 ->
//    penable high for 3 cycles, rsp_rdata=0x12345678, rsp_code=0.
//  3 Decode error: addr=0x1F with NSLV=2 -> psel stays 0, rsp_valid next cycle, rsp_code=2.
//  4 Slave error: pslverr[1]=1 with pready -> rsp_code=1; next request accepted in the rsp_valid cycle.
//  5 Timeout: TIMEOUT=4, pready held 0 -> abort after 4 ACCESS cycles, rsp_code=3, psel=0.
//  6 Reset asserted during ACCESS -> psel/penable=0 immediately, no rsp_valid,
//    next request completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB bridge definitions: FSM state encoding and response codes.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

  localparam logic [1:0] RSP_OK      = 2'd0;
  localparam logic [1:0] RSP_SLVERR  = 2'd1;
  localparam logic [1:0] RSP_DECERR  = 2'd2;
  localparam logic [1:0] RSP_TIMEOUT = 2'd3;

  // A disabled timeout still needs a one-bit counter to keep the declaration legal.
  function automatic int unsigned cnt_width(int unsigned timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slave decode: slave index field -> one-hot select plus decode-error flag.
module apb_addr_decoder #(
  parameter int unsigned IW   = 2,
  parameter int unsigned NSLV = 2
) (
  input  logic [IW-1:0]   slv_idx,
  output logic [NSLV-1:0] sel,
  output logic            dec_err
);

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      sel[i] = (slv_idx == IW'(i));
    end
    dec_err = ~|sel;
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB master bridge: CPU valid/ready request port to NSLV APB slaves, with decode-error
// and per-transfer PREADY timeout responses.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 32,
  parameter int unsigned NSLV    = 2,
  parameter int unsigned SEL_LSB = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             pclk,
  input  logic             Reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_wdata,
  output logic             rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic [1:0]       rsp_code,
  output logic [NSLV-1:0]  psel,
  output logic             penable,
  output logic             pwrite,
  output logic [AW-1:0]    paddr,
  output logic [DW-1:0]    pwdata,
  input  logic [NSLV-1:0]  pready,
  input  logic [NSLV-1:0]  pslverr,
  input  logic [NSLV*DW-1:0] prdata
);

  localparam int unsigned IW = AW - SEL_LSB;
  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  apb_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NSLV-1:0] sel_q, sel_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [1:0]      rsp_code_q, rsp_code_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic [NSLV-1:0] dec_sel;
  logic            dec_err;
  logic            sel_ready;
  logic            sel_err;
  logic [DW-1:0]   rdata_mux;

  apb_addr_decoder #(
    .IW   (IW),
    .NSLV (NSLV)
  ) u_decoder (
    .slv_idx (req_addr[AW-1:SEL_LSB]),
    .sel     (dec_sel),
    .dec_err (dec_err)
  );

  // Only the latched slave's handshake and data are ever looked at.
  always_comb begin
    sel_ready = |(pready & sel_q);
    sel_err   = |(pslverr & sel_q);
    rdata_mux = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (sel_q[i]) begin
        rdata_mux = rdata_mux | prdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_code_d  = rsp_code_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          if (dec_err) begin
            // Unmapped address: answer immediately without touching the bus.
            rsp_valid_d = 1'b1;
            rsp_code_d  = RSP_DECERR;
          end else begin
            sel_d   = dec_sel;
            cnt_d   = '0;
            state_d = StSetup;
          end
        end
      end

      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end

      StAccess: begin
        if (sel_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_code_d  = sel_err ? RSP_SLVERR : RSP_OK;
          if (!pwrite_q) begin
            rsp_rdata_d = rdata_mux;
          end
        end else if (TIMEOUT != 0) begin
          if (cnt_q == CNT_LAST) begin
            state_d     = StIdle;
            rsp_valid_d = 1'b1;
            rsp_code_d  = RSP_TIMEOUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sel_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= RSP_OK;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign psel      = (state_q == StIdle) ? '0 : sel_q;
  assign penable   = (state_q == StAccess);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_code  = rsp_code_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus randomized transfers
// checked against a transaction-level latency/response model.
module tb_apb_master_bridge;

  localparam int AW      = 5;
  localparam int DW      = 32;
  localparam int NSLV    = 2;
  localparam int SEL_LSB = 3;
  localparam int TIMEOUT = 4;

  logic              pclk = 1'b0;
  logic              Reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [AW-1:0]     req_addr;
  logic [DW-1:0]     req_wdata;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [1:0]        rsp_code;
  logic [NSLV-1:0]   psel;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [NSLV-1:0]   pready;
  logic [NSLV-1:0]   pslverr;
  logic [NSLV*DW-1:0] prdata;

  int vectors     = 0;
  int miscompares = 0;
  logic [DW-1:0] last_rdata;

  always #5 pclk = ~pclk;

  apb_master_bridge #(
    .AW      (AW),
    .DW      (DW),
    .NSLV    (NSLV),
    .SEL_LSB (SEL_LSB),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk      (pclk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_code  (rsp_code),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .prdata    (prdata)
  );

  // Random noise on every slave; the addressed one (if any) gets the given values.
  task automatic drive_slaves(input int idx, input bit rdy, input bit err,
                              input logic [DW-1:0] rd);
    for (int i = 0; i < NSLV; i++) begin
      pready[i]          = 1'($urandom);
      pslverr[i]         = 1'($urandom);
      prdata[i*DW +: DW] = $urandom;
    end
    if (idx >= 0) begin
      pready[idx]          = rdy;
      pslverr[idx]         = err;
      prdata[idx*DW +: DW] = rd;
    end
  endtask

  // Starts and ends at a negedge with the bridge idle; the response cycle is the end point,
  // so consecutive calls exercise back-to-back acceptance.
  task automatic do_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int waits, input bit err, input logic [DW-1:0] rd,
                         input string name);
    int idx;
    bit dec;
    int lat;
    logic [1:0] code;
    logic [NSLV-1:0] exp_psel;
    bit exp_pen;
    bit rdy;
    idx = int'(addr[AW-1:SEL_LSB]);
    dec = (idx >= NSLV);
    if (dec) begin
      lat  = 1;
      code = 2'd2;
    end else if (waits + 1 <= TIMEOUT) begin
      lat  = waits + 3;
      code = err ? 2'd1 : 2'd0;
    end else begin
      lat  = TIMEOUT + 2;
      code = 2'd3;
    end

    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s req_ready before accept: got %b expected 1", name, req_ready);
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;

    for (int k = 1; k <= lat; k++) begin
      @(posedge pclk);
      #1;
      if (k == 1) begin
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
      end
      if (dec || k == lat) begin
        drive_slaves(-1, 1'b0, 1'b0, '0);
      end else begin
        // SETUP sees pready=1 on purpose: it must be ignored there.
        rdy = (k == 1) ? 1'b1 : (k - 1 == waits + 1);
        drive_slaves(idx, rdy, err, rdy ? rd : $urandom);
      end
      @(negedge pclk);

      exp_psel = '0;
      if (!dec && k < lat) exp_psel[idx] = 1'b1;
      exp_pen = !dec && k >= 2 && k < lat;
      vectors++;
      if (psel !== exp_psel) begin
        miscompares++;
        $display("FAIL %s psel cycle %0d: got %b expected %b", name, k, psel, exp_psel);
      end
      vectors++;
      if (penable !== exp_pen) begin
        miscompares++;
        $display("FAIL %s penable cycle %0d: got %b expected %b", name, k, penable, exp_pen);
      end
      vectors++;
      if (rsp_valid !== (k == lat)) begin
        miscompares++;
        $display("FAIL %s rsp_valid cycle %0d: got %b expected %b", name, k, rsp_valid,
                 (k == lat));
      end
      if (!dec && k < lat) begin
        vectors++;
        if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wdata)) begin
          miscompares++;
          $display("FAIL %s bus fields cycle %0d: got addr %h wr %b data %h expected %h %b %h",
                   name, k, paddr, pwrite, pwdata, addr, wr, wdata);
        end
      end
      if (k == lat) begin
        if (!dec && !wr && code != 2'd3) last_rdata = rd;
        vectors++;
        if (rsp_code !== code) begin
          miscompares++;
          $display("FAIL %s rsp_code: got %0d expected %0d", name, rsp_code, code);
        end
        vectors++;
        if (rsp_rdata !== last_rdata) begin
          miscompares++;
          $display("FAIL %s rsp_rdata: got %h expected %h", name, rsp_rdata, last_rdata);
        end
        vectors++;
        if (req_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL %s req_ready in rsp cycle: got %b expected 1", name, req_ready);
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      @(posedge pclk);
      #1;
      drive_slaves(-1, 1'b0, 1'b0, '0);
      @(negedge pclk);
      vectors++;
      if (rsp_valid !== 1'b0 || psel !== '0 || penable !== 1'b0) begin
        miscompares++;
        $display("FAIL %s idle: got rsp_valid %b psel %b penable %b expected 0 0 0",
                 name, rsp_valid, psel, penable);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge pclk);
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== '0 || penable !== 1'b0 ||
        pwrite !== 1'b0 || paddr !== '0 || pwdata !== '0 || rsp_rdata !== '0 ||
        rsp_code !== 2'd0) begin
      miscompares++;
      $display("FAIL reset state: got ready %b valid %b psel %b pen %b pwr %b addr %h wd %h rd %h code %0d expected 1 0 0 0 0 0 0 0 0",
               req_ready, rsp_valid, psel, penable, pwrite, paddr, pwdata, rsp_rdata, rsp_code);
    end
    @(posedge pclk);
    #1;
    Reset = 1'b0;
    last_rdata = '0;
    @(negedge pclk);
  endtask

  task automatic test_zero_wait_write();
    do_xfer(1'b1, 5'h02, 32'hDEADBEEF, 0, 1'b0, 32'h0, "zero_wait_write");
  endtask

  task automatic test_wait_read();
    do_xfer(1'b0, 5'h0A, 32'h0, 2, 1'b0, 32'h12345678, "wait_read");
  endtask

  task automatic test_decode_error();
    do_xfer(1'b0, 5'h1F, 32'h0, 0, 1'b0, 32'h0, "decode_error");
  endtask

  task automatic test_back_to_back();
    do_xfer(1'b1, 5'h0B, 32'hA5A5_0001, 0, 1'b1, 32'h0, "slverr_write");
    do_xfer(1'b0, 5'h01, 32'h0, 1, 1'b0, 32'hCAFE_F00D, "b2b_read");
    do_xfer(1'b0, 5'h0C, 32'h0, 0, 1'b1, 32'h0BAD_0BAD, "slverr_read");
  endtask

  task automatic test_timeout();
    do_xfer(1'b0, 5'h08, 32'h0, 20, 1'b0, 32'h0, "timeout");
    do_xfer(1'b0, 5'h00, 32'h0, TIMEOUT - 1, 1'b0, 32'h7777_1234, "last_chance_ready");
  endtask

  task automatic test_reset_in_access();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'h0A;
    req_wdata = '0;
    @(posedge pclk);
    #1;
    req_valid = 1'b0;
    drive_slaves(1, 1'b0, 1'b0, '0);
    @(posedge pclk);
    #1;
    drive_slaves(1, 1'b0, 1'b0, '0);
    @(posedge pclk);
    #1;
    Reset = 1'b1;
    #1;
    vectors++;
    if (psel !== '0 || penable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_access: got psel %b pen %b valid %b ready %b expected 0 0 0 1",
               psel, penable, rsp_valid, req_ready);
    end
    @(posedge pclk);
    #1;
    Reset = 1'b0;
    last_rdata = '0;
    @(negedge pclk);
    idle_cycles(3, "after_reset");
    do_xfer(1'b0, 5'h09, 32'h0, 1, 1'b0, 32'h1357_9BDF, "post_reset_read");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      do_xfer(1'($urandom), AW'($urandom), $urandom, int'($urandom_range(0, 6)),
              1'($urandom), $urandom, "random");
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)), "random_gap");
    end
  endtask

  initial begin
    Reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = '0;
    pslverr   = '0;
    prdata    = '0;
    last_rdata = '0;

    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_decode_error();
    test_back_to_back();
    test_timeout();
    test_reset_in_access();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
